wind_stats: RTL and testbench

WIND_STATS -- requirements
Module: wind_stats

---
 rtl/wind_pkg.sv | 18 +
 rtl/wind_acc.sv | 35 +++
 rtl/wind_stats.sv | 134 +++++++++++++
 tb/tb_wind_stats.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wind_pkg.sv
// Shared sizing, Q-format constants and control-state encoding for the wind statistics block.
// Defaults give 16-bit samples and windows of up to 2^10 samples.
package wind_pkg;

    localparam int DW         = 16;
    localparam int WINLEN_MAX = 10;
    localparam int ACC_W      = DW + WINLEN_MAX;

    // Fraction bits: speed/components are Q5.10, direction is Q8.7.
    localparam int FRAC_SPEED = 10;
    localparam int FRAC_DIR   = 7;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/wind_acc.sv
// Per-axis window accumulator; mean is the floor of the running sum (incl. current sample) / 2^shamt.
// Latency: mean is combinational from the current sample; no backpressure, the parent decides when to keep it.
// Backpressure: none; accumulates on every en cycle and restarts on close.
module wind_acc
    import wind_pkg::*;
#(
    parameter int DW = wind_pkg::DW,
    parameter int AW = wind_pkg::ACC_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 first,
    input  logic                 close,
    input  logic signed [DW-1:0] sample,
    input  logic [3:0]           shamt,
    output logic signed [DW-1:0] mean
);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;

    // The first sample of a window ignores whatever the register still holds.
    assign acc_sum = (first ? '0 : acc) + {{(AW-DW){sample[DW-1]}}, sample};
    assign mean    = DW'(acc_sum >>> shamt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= close ? '0 : acc_sum;
        end
    end

endmodule

// File: rtl/wind_stats.sv
// Windowed wind statistics: component means and gust peak over 2^winlen samples.
// Latency: result registers load on the edge after the closing sample (1 cycle).
// Backpressure: valid/ready; a close while a result is unread drops it and sets sticky overrun.
module wind_stats
    import wind_pkg::*;
#(
    parameter int DW         = wind_pkg::DW,
    parameter int WINLEN_MAX = wind_pkg::WINLEN_MAX
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 speeden,
    input  logic signed [DW-1:0] speed,
    input  logic signed [DW-1:0] speedX,
    input  logic signed [DW-1:0] speedY,
    input  logic signed [DW-1:0] direction,
    input  logic [3:0]           winlen,
    output logic signed [DW-1:0] avgX,
    output logic signed [DW-1:0] avgY,
    output logic signed [DW-1:0] peak,
    output logic signed [DW-1:0] peakdir,
    output logic                 statvalid,
    input  logic                 statready,
    output logic                 overrun
);

    localparam int CW = WINLEN_MAX + 1;

    state_t state, state_nxt;

    logic [CW-1:0]        cnt, cnt_inc, target;
    logic [3:0]           wl_reg, wl_clamp, wl_cur;
    logic                 first, close, load, ovr_set, ovr_clr, take;
    logic signed [DW-1:0] pk, pkdir, pk_cand, pkdir_cand;
    logic signed [DW-1:0] mean_x, mean_y;

    assign wl_clamp = (winlen > 4'(WINLEN_MAX)) ? 4'(WINLEN_MAX) : winlen;
    assign first    = (cnt == '0);
    // The window length is frozen at the first sample; later winlen changes wait for the next window.
    assign wl_cur   = first ? wl_clamp : wl_reg;
    assign cnt_inc  = cnt + CW'(1);
    assign target   = CW'(1) << wl_cur;
    assign close    = speeden && (cnt_inc == target);

    assign take       = first || (speed > pk);
    assign pk_cand    = take ? speed : pk;
    assign pkdir_cand = take ? direction : pkdir;

    wind_acc #(.DW(DW), .AW(DW + WINLEN_MAX)) u_acc_x (
        .clock  (clock),
        .reset  (reset),
        .en     (speeden),
        .first  (first),
        .close  (close),
        .sample (speedX),
        .shamt  (wl_cur),
        .mean   (mean_x)
    );

    wind_acc #(.DW(DW), .AW(DW + WINLEN_MAX)) u_acc_y (
        .clock  (clock),
        .reset  (reset),
        .en     (speeden),
        .first  (first),
        .close  (close),
        .sample (speedY),
        .shamt  (wl_cur),
        .mean   (mean_y)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            wl_reg <= '0;
            pk     <= '0;
            pkdir  <= '0;
        end else if (speeden) begin
            if (first) begin
                wl_reg <= wl_clamp;
            end
            cnt   <= close ? '0 : cnt_inc;
            pk    <= close ? '0 : pk_cand;
            pkdir <= close ? '0 : pkdir_cand;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (close) state_nxt = ST_PEND;
            ST_PEND: if (statready && !close) state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    always_comb begin
        statvalid = (state == ST_PEND);
        load      = close && (!statvalid || statready);
        ovr_set   = close && statvalid && !statready;
        // A consume that coincides with a fresh close leaves overrun as it was.
        ovr_clr   = statvalid && statready && !close;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avgX    <= '0;
            avgY    <= '0;
            peak    <= '0;
            peakdir <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                avgX    <= mean_x;
                avgY    <= mean_y;
                peak    <= pk_cand;
                peakdir <= pkdir_cand;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wind_stats.sv
// Randomized and directed bench for wind_stats against a window-queue reference model.
module tb_wind_stats;
    import wind_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 speeden = 1'b0;
    logic signed [15:0]   speed = '0, speedX = '0, speedY = '0, direction = '0;
    logic [3:0]           winlen = '0;
    logic                 statready = 1'b0;
    logic signed [15:0]   avgX, avgY, peak, peakdir;
    logic                 statvalid, overrun;

    int checks = 0;
    int errors = 0;

    wind_stats dut (
        .clock     (clock),
        .reset     (reset),
        .speeden   (speeden),
        .speed     (speed),
        .speedX    (speedX),
        .speedY    (speedY),
        .direction (direction),
        .winlen    (winlen),
        .avgX      (avgX),
        .avgY      (avgY),
        .peak      (peak),
        .peakdir   (peakdir),
        .statvalid (statvalid),
        .statready (statready),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic signed [15:0] sp;
        logic signed [15:0] sx;
        logic signed [15:0] sy;
        logic signed [15:0] dir;
    } smp_t;

    smp_t win[$];
    int   m_wl = 0;
    logic signed [15:0] e_avgx = '0, e_avgy = '0, e_peak = '0, e_pdir = '0;
    bit   e_valid = 1'b0, e_ovr = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [15:0] floor_mean(input longint sum, input int wl);
        longint n, q;
        logic [63:0] qb;
        n = longint'(1) << wl;
        if (sum >= 0) q = sum / n;
        else          q = -((-sum + n - 1) / n);
        qb = q;
        return qb[15:0];
    endfunction

    task automatic model_clear();
        win.delete();
        m_wl = 0;
        e_avgx = '0; e_avgy = '0; e_peak = '0; e_pdir = '0;
        e_valid = 1'b0; e_ovr = 1'b0;
    endtask

    // Applies the block's rules to the inputs sampled at this rising edge.
    task automatic model_edge();
        bit closed = 1'b0;
        logic signed [15:0] r_ax, r_ay, r_pk, r_pd;
        longint sx_sum, sy_sum;
        smp_t s;
        r_ax = '0; r_ay = '0; r_pk = '0; r_pd = '0;
        if (speeden) begin
            if (win.size() == 0) m_wl = (int'(winlen) > WINLEN_MAX) ? WINLEN_MAX : int'(winlen);
            s.sp = speed; s.sx = speedX; s.sy = speedY; s.dir = direction;
            win.push_back(s);
            if (win.size() == (1 << m_wl)) begin
                sx_sum = 0; sy_sum = 0;
                r_pk = win[0].sp; r_pd = win[0].dir;
                foreach (win[i]) begin
                    sx_sum += longint'(win[i].sx);
                    sy_sum += longint'(win[i].sy);
                    if (win[i].sp > r_pk) begin
                        r_pk = win[i].sp; r_pd = win[i].dir;
                    end
                end
                r_ax = floor_mean(sx_sum, m_wl);
                r_ay = floor_mean(sy_sum, m_wl);
                win.delete();
                closed = 1'b1;
            end
        end
        if (closed) begin
            if (!e_valid || statready) begin
                e_avgx = r_ax; e_avgy = r_ay; e_peak = r_pk; e_pdir = r_pd;
                e_valid = 1'b1;
            end else begin
                e_ovr = 1'b1;
            end
        end else if (e_valid && statready) begin
            e_valid = 1'b0;
            e_ovr = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("avgX", avgX, e_avgx);
        chk("avgY", avgY, e_avgy);
        chk("peak", peak, e_peak);
        chk("peakdir", peakdir, e_pdir);
        chk("statvalid", statvalid, e_valid);
        chk("overrun", overrun, e_ovr);
    endtask

    task automatic step(input bit en, input int sp, input int sx, input int sy, input int dr,
                        input int wl, input bit rdy);
        @(negedge clock);
        speeden = en; speed = 16'(sp); speedX = 16'(sx); speedY = 16'(sy);
        direction = 16'(dr); winlen = 4'(wl); statready = rdy;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        speeden = 1'b0;
        model_clear();
        #1;
        compare_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int one;
        one = 1 << FRAC_SPEED;

        #2;
        model_clear();
        compare_all();
        chk("reset_statvalid", statvalid, 0);
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 1);

        // Mean of 1.0..4.0 over a 4-sample window.
        for (int i = 1; i <= 4; i++) step(1, 100, i * one, 0, 0, 2, 1);
        chk("r034_avgx", avgX, 2560);
        chk("r034_valid", statvalid, 1);
        step(0, 0, 0, 0, 0, 2, 1);

        step(1, 0, 0, -3, 0, 1, 1);
        step(1, 0, 0, -2, 0, 1, 1);
        chk("r035_avgy_floor", avgY, -3);
        step(1, 500, 0, 0, 10, 2, 1);
        step(1, 700, 0, 0, 20, 2, 1);
        step(1, 700, 0, 0, 30, 2, 1);
        step(1, 100, 0, 0, 40, 2, 1);
        chk("r035_peak", peak, 700);
        chk("r035_peakdir_first_tie", peakdir, 20);
        step(0, 0, 0, 0, 0, 2, 1);

        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 2, 9, 0, 0, 0, 0);
        chk("r036_held_avgx", avgX, 5);
        chk("r036_overrun", overrun, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("r036_valid_cleared", statvalid, 0);
        chk("r036_overrun_cleared", overrun, 0);

        for (int i = 0; i < 1023; i++) step(1, 1, 32767, -32768, 0, 15, 1);
        chk("r037_not_closed_1023", statvalid, 0);
        step(1, 1, 32767, -32768, 0, 15, 1);
        chk("r037_closed_1024", statvalid, 1);
        chk("r037_fullscale_x", avgX, 32767);
        chk("r037_fullscale_y", avgY, -32768);
        step(0, 0, 0, 0, 0, 0, 1);

        step(1, 0, 7000, 0, 0, 2, 1);
        step(1, 0, 7000, 0, 0, 2, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 100, 0, 0, 2, 1);
        chk("r038_after_reset", avgX, 100);
        step(0, 0, 0, 0, 0, 2, 1);

        step(1, 0, 10, 0, 0, 2, 1);
        step(1, 0, 20, 0, 0, 1, 1);
        chk("r038_no_early_close", statvalid, 0);
        step(1, 0, 30, 0, 0, 1, 1);
        step(1, 0, 40, 0, 0, 1, 1);
        chk("r038_wl_change_avg", avgX, 25);
        chk("r038_wl_change_valid", statvalid, 1);

        for (int i = 0; i < 3000; i++) begin
            int wl;
            wl = ($urandom_range(0, 199) == 0) ? 12 : int'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 9) < 7, int'($urandom), int'($urandom), int'($urandom),
                 int'($urandom_range(0, 359)) << FRAC_DIR, wl, $urandom_range(0, 9) < 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
